// File: rtl/spi_pwm_pkg.sv
// Shared constants for the SPI-programmed PWM bank: register map, frame size and SPI FSM states.
package spi_pwm_pkg;
  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_OUT_EN = 7'h00;
  localparam logic [6:0] ADDR_PWM_EN = 7'h01;
  localparam logic [6:0] ADDR_PRESC  = 7'h02;
  localparam logic [6:0] ADDR_DUTY0  = 7'h03;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} spi_state_e;
endpackage

// File: rtl/spi_pwm_sync.sv
// STAGES-deep synchroniser plus an edge-detect flop; rise/fall are one-clk pulses.
// Latency: STAGES clk to level, edges visible combinationally from it; no backpressure.
module spi_pwm_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_pwm_bank.sv
// SPI mode-0 register file driving NUM_CH static/PWM outputs; writes land 1 clk after COMMIT,
// ch_out is registered 1 clk after its inputs; SPI has no backpressure (f_sclk <= f_clk/8).
module spi_pwm_bank
  import spi_pwm_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int PWM_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spi_sclk,
  input  logic              spi_copi,
  input  logic              spi_cs_n,
  output logic              spi_cipo,
  output logic [NUM_CH-1:0] ch_out
);
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused_sync;

  spi_pwm_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din_i(spi_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_pwm_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din_i(spi_copi),
    .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall));
  spi_pwm_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din_i(spi_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

  assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall, cs_lvl};

  spi_state_e        state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]       shift_q, shift_d;
  logic [7:0]        rd_q, rd_d;
  logic              rd_act_q, rd_act_d;
  logic              cipo_q, cipo_d;
  logic              commit_wr;

  logic [NUM_CH-1:0]   out_en_q, pwm_en_q;
  logic [7:0]          presc_q;
  logic [PWM_BITS-1:0] duty_q [NUM_CH];

  // Address completes on the 8th rise, so decode from the bit arriving this clk.
  logic [6:0] rd_addr;
  logic [7:0] rd_val;
  assign rd_addr = {shift_q[5:0], copi_lvl};

  always_comb begin
    rd_val = 8'h00;
    if (rd_addr == ADDR_OUT_EN) rd_val = 8'(out_en_q);
    if (rd_addr == ADDR_PWM_EN) rd_val = 8'(pwm_en_q);
    if (rd_addr == ADDR_PRESC)  rd_val = presc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_DUTY0 + 7'(i)) rd_val = 8'(duty_q[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    rd_act_d  = rd_act_q;
    cipo_d    = cipo_q;
    commit_wr = 1'b0;
    case (state_q)
      IDLE: begin
        cipo_d   = 1'b0;
        rd_act_d = 1'b0;
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_lvl};
          if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7 && !shift_q[6]) begin
            rd_d     = rd_val;
            rd_act_d = 1'b1;
          end
        end
        if (sclk_fall) begin
          if (rd_act_q && bit_cnt_q >= 5'd8 && bit_cnt_q < 5'd16) begin
            cipo_d = rd_q[7];
            rd_d   = {rd_q[6:0], 1'b0};
          end else begin
            cipo_d = 1'b0;
          end
        end
        // An sclk edge coincident with cs_n rise is already folded into bit_cnt_d.
        if (cs_rise) state_d = (bit_cnt_d == 5'(FRAME_BITS)) ? COMMIT : IDLE;
      end
      COMMIT: begin
        commit_wr = shift_q[15];
        cipo_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!ena) begin
      state_d   = IDLE;
      cipo_d    = 1'b0;
      commit_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rd_q      <= '0;
      rd_act_q  <= 1'b0;
      cipo_q    <= 1'b0;
      out_en_q  <= '0;
      pwm_en_q  <= '0;
      presc_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      rd_act_q  <= rd_act_d;
      cipo_q    <= cipo_d;
      if (commit_wr) begin
        if (shift_q[14:8] == ADDR_OUT_EN) out_en_q <= shift_q[NUM_CH-1:0];
        if (shift_q[14:8] == ADDR_PWM_EN) pwm_en_q <= shift_q[NUM_CH-1:0];
        if (shift_q[14:8] == ADDR_PRESC)  presc_q  <= shift_q[7:0];
        for (int i = 0; i < NUM_CH; i++) begin
          if (shift_q[14:8] == ADDR_DUTY0 + 7'(i)) duty_q[i] <= shift_q[PWM_BITS-1:0];
        end
      end
    end
  end

  logic [7:0]          psc_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty_s_q [NUM_CH];
  logic                load_pend_q;
  logic                tick;
  logic [NUM_CH-1:0]   pwm_lvl;
  logic [NUM_CH-1:0]   ch_q;

  // Comparing with >= lets a lowered PRESC wrap at once instead of running to 255.
  assign tick = ena && (psc_q >= presc_q);

  always_comb begin
    pwm_lvl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_lvl[i] = (&duty_s_q[i]) | (cnt_q < duty_s_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_q       <= '0;
      cnt_q       <= '0;
      load_pend_q <= 1'b1;
      ch_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_s_q[i] <= '0;
    end else begin
      if (ena) psc_q <= tick ? 8'd0 : psc_q + 8'd1;
      if (tick) begin
        cnt_q <= cnt_q + PWM_BITS'(1);
        if ((&cnt_q) || load_pend_q) begin
          load_pend_q <= 1'b0;
          for (int i = 0; i < NUM_CH; i++) duty_s_q[i] <= duty_q[i];
        end
      end
      ch_q <= out_en_q & (~pwm_en_q | pwm_lvl);
    end
  end

  assign ch_out   = ch_q;
  assign spi_cipo = cipo_q;
endmodule

// File: tb/tb_spi_pwm_bank.sv
// Bench for spi_pwm_bank: an 8-channel/8-bit instance and a 4-channel/4-bit instance share the SPI pins.
module tb_spi_pwm_bank;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n, ena, sclk, copi, cs_n;
  logic       cipo8, cipo4;
  logic [7:0] ch8;
  logic [3:0] ch4;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] mem8 [128];
  logic [7:0] mem4 [128];

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] dat;
    logic [7:0] exp8;
    logic [7:0] exp4;
  } vec_t;
  vec_t tbl [14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_pwm_bank #(.NUM_CH(8), .PWM_BITS(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spi_sclk(sclk), .spi_copi(copi),
    .spi_cs_n(cs_n), .spi_cipo(cipo8), .ch_out(ch8));
  spi_pwm_bank #(.NUM_CH(4), .PWM_BITS(4), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spi_sclk(sclk), .spi_copi(copi),
    .spi_cs_n(cs_n), .spi_cipo(cipo4), .ch_out(ch4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wmask(input int a, input int nch, input int pwb);
    if (a == 0 || a == 1) return 8'((1 << nch) - 1);
    if (a == 2) return 8'hFF;
    if (a >= 3 && a < 3 + nch) return 8'((1 << pwb) - 1);
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      mem8[i] = 8'h00;
      mem4[i] = 8'h00;
    end
  endtask

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    mem8[a] = d & wmask(int'(a), 8, 8);
    mem4[a] = d & wmask(int'(a), 4, 4);
  endtask

  task automatic spi_bit(input logic b, output logic c8, output logic c4);
    copi = b;
    repeat (H) @(negedge clk);
    c8 = cipo8;
    c4 = cipo4;
    sclk = 1'b1;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Sends w[nbits-1:0] MSB first; captures cipo at the rises of bits 8..15.
  task automatic spi_xfer(input logic [16:0] w, input int nbits,
                          output logic [7:0] r8, output logic [7:0] r4);
    logic c8, c4;
    r8 = 8'h00;
    r4 = 8'h00;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(w[i], c8, c4);
      if (nbits - 1 - i >= 8 && nbits - 1 - i < 16) begin
        r8 = {r8[6:0], c8};
        r4 = {r4[6:0], c4};
      end
    end
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] r8, r4;
    spi_xfer({2'b01, a, d}, 16, r8, r4);
    repeat (6) @(negedge clk);
    model_write(a, d);
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] r8, output logic [7:0] r4);
    spi_xfer({2'b00, a, 8'h00}, 16, r8, r4);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_ch0(input logic val, input int budget, input string name, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ch8[0] === val) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL %s: ch_out[0] never reached %0b within %0d clk", name, val, budget);
    end
  endtask

  task automatic check_static(input string name);
    check({name, "_ch8"}, ch8 & ~mem8[1], mem8[0] & ~mem8[1]);
    check({name, "_ch4"}, {4'h0, ch4} & ~mem4[1], mem4[0] & ~mem4[1]);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r8, r4;
    logic       c8, c4;
    logic [6:0] a;
    logic [7:0] d;
    logic [15:0] w16;
    int         t_r1, t_f1, t_r2, hits, found;

    tbl[0]  = '{1'b1, 7'h05, 8'h5A, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 7'h05, 8'h00, 8'h5A, 8'h0A};
    tbl[2]  = '{1'b1, 7'h00, 8'hFF, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 7'h00, 8'h00, 8'hFF, 8'h0F};
    tbl[4]  = '{1'b1, 7'h7F, 8'h33, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 7'h7F, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{1'b1, 7'h07, 8'hC3, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 7'h07, 8'h00, 8'hC3, 8'h00};
    tbl[8]  = '{1'b1, 7'h0A, 8'h81, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 7'h0A, 8'h00, 8'h81, 8'h00};
    tbl[10] = '{1'b1, 7'h02, 8'hA5, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 7'h02, 8'h00, 8'hA5, 8'hA5};
    tbl[12] = '{1'b1, 7'h01, 8'h3C, 8'h00, 8'h00};
    tbl[13] = '{1'b0, 7'h01, 8'h00, 8'h3C, 8'h0C};

    rst_n = 1'b0; ena = 1'b1; sclk = 1'b0; copi = 1'b0; cs_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ch8", ch8, 8'h00);
    check("rst_ch4", ch4, 4'h0);
    check("rst_cipo", cipo8, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i <= 10; i++) begin
      spi_read(7'(i), r8, r4);
      check($sformatf("rst_rd%0h_8", i), r8, 8'h00);
      check($sformatf("rst_rd%0h_4", i), r4, 8'h00);
    end

    // Static enable: visible on ch_out within SYNC_STAGES+3 clk of cs_n rise.
    spi_write(7'h01, 8'h00);
    spi_xfer({2'b01, 7'h00, 8'hFF}, 16, r8, r4);
    found = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ch8 == 8'hFF && found == 0) found = k + 1;
    end
    model_write(7'h00, 8'hFF);
    check("latency_found", (found != 0), 1'b1);
    check("static_ch4", ch4, 4'hF);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) spi_write(tbl[i].addr, tbl[i].dat);
      else begin
        spi_read(tbl[i].addr, r8, r4);
        check($sformatf("tbl%0d_rd8", i), r8, tbl[i].exp8);
        check($sformatf("tbl%0d_rd4", i), r4, tbl[i].exp4);
      end
    end

    // Aborted frames: 12 bits, then 17 bits, must not disturb PRESC.
    spi_xfer(17'({1'b1, 7'h02, 4'h9}), 12, r8, r4);
    repeat (6) @(negedge clk);
    spi_read(7'h02, r8, r4);
    check("abort12", r8, mem8[2]);
    spi_xfer({1'b1, 7'h02, 8'h99, 1'b0}, 17, r8, r4);
    repeat (6) @(negedge clk);
    spi_read(7'h02, r8, r4);
    check("abort17", r8, mem8[2]);

    // ena dropped mid-frame discards the frame even though 16 bits arrive.
    w16 = {1'b1, 7'h02, 8'h77};
    @(negedge clk);
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 15; i >= 6; i--) spi_bit(w16[i], c8, c4);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    for (int i = 5; i >= 0; i--) spi_bit(w16[i], c8, c4);
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    spi_read(7'h02, r8, r4);
    check("ena_abort", r8, mem8[2]);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 12));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) spi_write(a, d);
      else begin
        spi_read(a, r8, r4);
        check($sformatf("rnd%0d_rd8_a%0h", n, a), r8, mem8[a]);
        check($sformatf("rnd%0d_rd4_a%0h", n, a), r4, mem4[a]);
      end
      check_static($sformatf("rnd%0d", n));
    end

    // PWM on ch0 with PRESC=0.
    spi_write(7'h02, 8'h00);
    spi_write(7'h03, 8'h00);
    spi_write(7'h00, 8'h01);
    spi_write(7'h01, 8'h01);
    repeat (600) @(negedge clk);
    hits = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ch8[0]) hits++;
    end
    check("duty00_const0", hits, 0);
    spi_write(7'h03, 8'h80);
    wait_ch0(1'b1, 1000, "d80_rise1", t_r1);
    wait_ch0(1'b0, 1000, "d80_fall", t_f1);
    wait_ch0(1'b1, 1000, "d80_rise2", t_r2);
    check("d80_high", t_f1 - t_r1, 128);
    check("d80_low", t_r2 - t_f1, 128);
    spi_write(7'h03, 8'hFF);
    repeat (600) @(negedge clk);
    hits = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ch8[0]) hits++;
    end
    check("dutyFF_const1", hits, 300);

    // Duty change mid-period at PRESC=7 (each count lasts 8 clk).
    spi_write(7'h02, 8'h07);
    spi_write(7'h03, 8'h40);
    wait_ch0(1'b0, 5000, "d40_settle", t_f1);
    wait_ch0(1'b1, 5000, "d40_rise", t_r1);
    spi_write(7'h03, 8'hC0);
    wait_ch0(1'b0, 3000, "d40_fall", t_f1);
    check("d40_high_kept", t_f1 - t_r1, 64 * 8);
    wait_ch0(1'b1, 3000, "dC0_rise", t_r2);
    wait_ch0(1'b0, 3000, "dC0_fall", t_f1);
    check("dC0_high", t_f1 - t_r2, 192 * 8);

    // Reset pulsed mid-frame, then a normal write.
    w16 = {1'b1, 7'h02, 8'h55};
    @(negedge clk);
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 15; i >= 10; i--) spi_bit(w16[i], c8, c4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_ch8", ch8, 8'h00);
    spi_read(7'h00, r8, r4);
    check("midrst_outen", r8, 8'h00);
    spi_write(7'h02, 8'h42);
    spi_read(7'h02, r8, r4);
    check("midrst_wr8", r8, 8'h42);
    check("midrst_wr4", r4, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
